// File: rtl/lsq_dmem_arbiter_if.sv
// lsq_dmem_arbiter_if
//   Bundles the LSQ-side request/response handshakes and the data-cache port
//   of lsq_dmem_arbiter.
//   slave  : arbiter view (takes requests, drives responses and the cache request)
//   master : environment view (LSQ plus data cache)
//   Signals:
//     ld_req_*  : load request handshake plus addr/rmask/tag payload
//     st_req_*  : committed-store request handshake plus addr/wmask/wdata payload
//     ld_resp_* : load completion (valid pulse, data, tag)
//     st_done   : store-written pulse
//     dmem_*    : cache request (addr/masks/wdata) and response (rdata/resp)
interface lsq_dmem_arbiter_if #(
  parameter int TAG_WIDTH = 6
) ();
  logic                 ld_req_valid;
  logic                 ld_req_ready;
  logic [31:0]          ld_req_addr;
  logic [3:0]           ld_req_rmask;
  logic [TAG_WIDTH-1:0] ld_req_tag;

  logic                 st_req_valid;
  logic                 st_req_ready;
  logic [31:0]          st_req_addr;
  logic [3:0]           st_req_wmask;
  logic [31:0]          st_req_wdata;

  logic                 ld_resp_valid;
  logic [31:0]          ld_resp_rdata;
  logic [TAG_WIDTH-1:0] ld_resp_tag;
  logic                 st_done;

  logic [31:0]          dmem_addr;
  logic [3:0]           dmem_rmask;
  logic [3:0]           dmem_wmask;
  logic [31:0]          dmem_wdata;
  logic [31:0]          dmem_rdata;
  logic                 dmem_resp;

  modport slave (
    input  ld_req_valid, ld_req_addr, ld_req_rmask, ld_req_tag,
    output ld_req_ready,
    input  st_req_valid, st_req_addr, st_req_wmask, st_req_wdata,
    output st_req_ready,
    output ld_resp_valid, ld_resp_rdata, ld_resp_tag, st_done,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport master (
    output ld_req_valid, ld_req_addr, ld_req_rmask, ld_req_tag,
    input  ld_req_ready,
    output st_req_valid, st_req_addr, st_req_wmask, st_req_wdata,
    input  st_req_ready,
    input  ld_resp_valid, ld_resp_rdata, ld_resp_tag, st_done,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/lsq_dmem_arbiter.sv
// lsq_dmem_arbiter
//   Shares the single data-memory port between out-of-order load issue and
//   in-order committed-store drain. One transaction is outstanding at a time;
//   stores win ties until a waiting load has lost STARVE_LIMIT times in a row.
//   A branch flush kills a pending load request and any unreturned load data.
//   Ports:
//     clk      : core clock
//     rst_n    : asynchronous active-low reset
//     br_flush : branch flush
//     bus      : request/response handshakes and the dmem_* cache port
//     busy     : a transaction is outstanding
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no transaction outstanding; readys may assert
//   LD_WAIT | load issued to the cache, waiting for dmem_resp
//   ST_WAIT | store issued to the cache, waiting for dmem_resp
//   LD_DROP | load killed by a flush, waiting for dmem_resp to discard it
module lsq_dmem_arbiter #(
  parameter int TAG_WIDTH    = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                br_flush,
  lsq_dmem_arbiter_if.slave   bus,
  output logic                busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_WAIT = 2'd2,
    LD_DROP = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     starve_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 ld_pick;
  logic                 ld_go;
  logic                 st_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    ld_pick          = 1'b0;
    bus.ld_req_ready = 1'b0;
    bus.st_req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // A flushed load never wins; the store then takes the slot even if
        // the load would have been forced through.
        ld_pick = bus.ld_req_valid && !br_flush &&
                  (!bus.st_req_valid || starve_q == STARVE_MAX);
        bus.ld_req_ready = ld_pick;
        bus.st_req_ready = bus.st_req_valid && !ld_pick;
        if (ld_pick)               state_d = LD_WAIT;
        else if (bus.st_req_valid) state_d = ST_WAIT;
      end
      LD_WAIT: begin
        if (bus.dmem_resp)  state_d = IDLE;
        else if (br_flush)  state_d = LD_DROP;
      end
      ST_WAIT: begin
        if (bus.dmem_resp) state_d = IDLE;
      end
      LD_DROP: begin
        if (bus.dmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_go = bus.ld_req_valid && bus.ld_req_ready;
  assign st_go = bus.st_req_valid && bus.st_req_ready;
  assign busy  = (state_q != IDLE);

  // Counts consecutive store wins over a waiting load. Clearing has
  // priority so a flush always restarts the fairness window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (br_flush || ld_go) begin
      starve_q <= '0;
    end else if (st_go && bus.ld_req_valid) begin
      if (starve_q != STARVE_MAX) starve_q <= starve_q + 1'b1;
    end else if (state_q == IDLE && !bus.ld_req_valid) begin
      starve_q <= '0;
    end
  end

  // Request side: address/wdata held until the next grant, masks are a
  // single-cycle strobe in the cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dmem_addr  <= '0;
      bus.dmem_rmask <= '0;
      bus.dmem_wmask <= '0;
      bus.dmem_wdata <= '0;
      tag_q          <= '0;
    end else begin
      bus.dmem_rmask <= '0;
      bus.dmem_wmask <= '0;
      if (ld_go) begin
        bus.dmem_addr  <= bus.ld_req_addr & 32'hFFFF_FFFC;
        bus.dmem_rmask <= bus.ld_req_rmask;
        tag_q          <= bus.ld_req_tag;
      end else if (st_go) begin
        bus.dmem_addr  <= bus.st_req_addr & 32'hFFFF_FFFC;
        bus.dmem_wmask <= bus.st_req_wmask;
        bus.dmem_wdata <= bus.st_req_wdata;
      end
    end
  end

  // Response side is fully registered so dmem_resp/rdata never reach an
  // output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ld_resp_valid <= 1'b0;
      bus.ld_resp_rdata <= '0;
      bus.ld_resp_tag   <= '0;
      bus.st_done       <= 1'b0;
    end else begin
      bus.ld_resp_valid <= 1'b0;
      bus.st_done       <= 1'b0;
      if (state_q == LD_WAIT && bus.dmem_resp && !br_flush) begin
        bus.ld_resp_valid <= 1'b1;
        bus.ld_resp_rdata <= bus.dmem_rdata;
        bus.ld_resp_tag   <= tag_q;
      end
      if (state_q == ST_WAIT && bus.dmem_resp) begin
        bus.st_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsq_dmem_arbiter.sv
module tb_lsq_dmem_arbiter;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic br_flush;
  logic busy;
  int   n_cmp = 0;
  int   n_err = 0;

  lsq_dmem_arbiter_if #(.TAG_WIDTH(TW)) bus ();

  lsq_dmem_arbiter #(.TAG_WIDTH(TW), .STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .br_flush (br_flush),
    .bus      (bus),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " busy"},       {31'd0, busy},              32'd0);
    chk({tag, " ld_resp_v"},  {31'd0, bus.ld_resp_valid}, 32'd0);
    chk({tag, " st_done"},    {31'd0, bus.st_done},       32'd0);
    chk({tag, " dmem_addr"},  bus.dmem_addr,              32'd0);
    chk({tag, " dmem_rmask"}, {28'd0, bus.dmem_rmask},    32'd0);
    chk({tag, " dmem_wmask"}, {28'd0, bus.dmem_wmask},    32'd0);
    chk({tag, " dmem_wdata"}, bus.dmem_wdata,             32'd0);
    chk({tag, " ld_rdata"},   bus.ld_resp_rdata,          32'd0);
    chk({tag, " ld_tag"},     {26'd0, bus.ld_resp_tag},   32'd0);
  endtask

  logic [9:0] exp_order;  // 1 = load granted, index 0 first
  logic       got_ld;

  initial begin
    rst_n = 1'b0;
    br_flush = 1'b0;
    bus.ld_req_valid = 1'b0; bus.ld_req_addr = '0; bus.ld_req_rmask = '0; bus.ld_req_tag = '0;
    bus.st_req_valid = 1'b0; bus.st_req_addr = '0; bus.st_req_wmask = '0; bus.st_req_wdata = '0;
    bus.dmem_rdata = '0; bus.dmem_resp = 1'b0;
    exp_order = 10'b10000_10000;

    // Reset state
    step();
    chk_idle_outputs("reset");
    chk("reset ld_ready", {31'd0, bus.ld_req_ready}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single load: resp 3 cycles after the mask
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h1000_0006;
    bus.ld_req_rmask = 4'b1100; bus.ld_req_tag = 6'd5;
    #1;
    chk("ld ready", {31'd0, bus.ld_req_ready}, 32'd1);
    chk("ld st_ready", {31'd0, bus.st_req_ready}, 32'd0);
    step();
    bus.ld_req_valid = 1'b0;
    #1;
    chk("ld dmem_addr", bus.dmem_addr, 32'h1000_0004);
    chk("ld rmask", {28'd0, bus.dmem_rmask}, 32'hC);
    chk("ld busy", {31'd0, busy}, 32'd1);
    chk("ld ready in wait", {31'd0, bus.ld_req_ready}, 32'd0);
    step();
    chk("ld rmask drop", {28'd0, bus.dmem_rmask}, 32'h0);
    chk("ld addr held", bus.dmem_addr, 32'h1000_0004);
    step();
    step();
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld no early resp", {31'd0, bus.ld_resp_valid}, 32'd0);
    step();
    bus.dmem_resp = 1'b0; bus.dmem_rdata = 32'h0;
    chk("ld resp valid", {31'd0, bus.ld_resp_valid}, 32'd1);
    chk("ld resp rdata", bus.ld_resp_rdata, 32'hDEAD_BEEF);
    chk("ld resp tag", {26'd0, bus.ld_resp_tag}, 32'd5);
    chk("ld busy done", {31'd0, busy}, 32'd0);
    step();
    chk("ld resp pulse", {31'd0, bus.ld_resp_valid}, 32'd0);
    chk("ld rdata hold", bus.ld_resp_rdata, 32'hDEAD_BEEF);

    // Single store
    bus.st_req_valid = 1'b1; bus.st_req_addr = 32'h2000_0008;
    bus.st_req_wmask = 4'b1111; bus.st_req_wdata = 32'h1234_5678;
    #1;
    chk("st ready", {31'd0, bus.st_req_ready}, 32'd1);
    step();
    bus.st_req_valid = 1'b0;
    chk("st wmask", {28'd0, bus.dmem_wmask}, 32'hF);
    chk("st rmask", {28'd0, bus.dmem_rmask}, 32'h0);
    chk("st addr", bus.dmem_addr, 32'h2000_0008);
    chk("st wdata", bus.dmem_wdata, 32'h1234_5678);
    step();
    chk("st wmask drop", {28'd0, bus.dmem_wmask}, 32'h0);
    chk("st wdata held", bus.dmem_wdata, 32'h1234_5678);
    chk("st busy", {31'd0, busy}, 32'd1);
    bus.dmem_resp = 1'b1;
    step();
    bus.dmem_resp = 1'b0;
    chk("st done", {31'd0, bus.st_done}, 32'd1);
    chk("st no ld resp", {31'd0, bus.ld_resp_valid}, 32'd0);
    step();
    chk("st done pulse", {31'd0, bus.st_done}, 32'd0);

    // Both valid continuously, cache answers in the mask cycle
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h0000_0300;
    bus.ld_req_rmask = 4'b0011; bus.ld_req_tag = 6'd7;
    bus.st_req_valid = 1'b1; bus.st_req_addr = 32'h0000_0400;
    bus.st_req_wmask = 4'b0001; bus.st_req_wdata = 32'h0000_00AA;
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hA5A5_A5A5;
    #1;
    for (int i = 0; i < 10; i++) begin
      got_ld = bus.ld_req_ready;
      chk($sformatf("starve grant %0d", i), {31'd0, got_ld}, {31'd0, exp_order[i]});
      chk($sformatf("starve one ready %0d", i),
          {31'd0, bus.ld_req_ready & bus.st_req_ready}, 32'd0);
      step();
      step();
    end
    bus.ld_req_valid = 1'b0; bus.st_req_valid = 1'b0; bus.dmem_resp = 1'b0;
    chk("starve last ld resp", {31'd0, bus.ld_resp_valid}, 32'd1);
    chk("starve last ld tag", {26'd0, bus.ld_resp_tag}, 32'd7);
    chk("starve last ld data", bus.ld_resp_rdata, 32'hA5A5_A5A5);
    step();

    // Flush in LD_WAIT -> LD_DROP
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h0000_0500; bus.ld_req_tag = 6'd9;
    step();
    bus.ld_req_valid = 1'b0;
    br_flush = 1'b1;
    step();
    br_flush = 1'b0;
    chk("drop busy", {31'd0, busy}, 32'd1);
    step();
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h0000_0BAD;
    step();
    bus.dmem_resp = 1'b0;
    chk("drop no resp", {31'd0, bus.ld_resp_valid}, 32'd0);
    chk("drop idle", {31'd0, busy}, 32'd0);
    chk("drop tag held", {26'd0, bus.ld_resp_tag}, 32'd7);
    bus.ld_req_valid = 1'b1;
    #1;
    chk("drop next grant", {31'd0, bus.ld_req_ready}, 32'd1);

    // Flush coincident with resp
    step();
    bus.ld_req_valid = 1'b0;
    br_flush = 1'b1; bus.dmem_resp = 1'b1;
    step();
    br_flush = 1'b0; bus.dmem_resp = 1'b0;
    chk("flush+resp idle", {31'd0, busy}, 32'd0);
    chk("flush+resp no resp", {31'd0, bus.ld_resp_valid}, 32'd0);
    step();
    chk("flush+resp still none", {31'd0, bus.ld_resp_valid}, 32'd0);

    // Flush in ST_WAIT: the store still completes
    bus.st_req_valid = 1'b1; bus.st_req_addr = 32'h0000_0600; bus.st_req_wdata = 32'h0000_0055;
    step();
    bus.st_req_valid = 1'b0;
    br_flush = 1'b1; bus.dmem_resp = 1'b1;
    step();
    br_flush = 1'b0; bus.dmem_resp = 1'b0;
    chk("st flush done", {31'd0, bus.st_done}, 32'd1);

    // Flush in IDLE with both valid
    bus.ld_req_valid = 1'b1; bus.st_req_valid = 1'b1; br_flush = 1'b1;
    #1;
    chk("idle flush st_ready", {31'd0, bus.st_req_ready}, 32'd1);
    chk("idle flush ld_ready", {31'd0, bus.ld_req_ready}, 32'd0);
    step();
    bus.ld_req_valid = 1'b0; bus.st_req_valid = 1'b0; br_flush = 1'b0;
    chk("idle flush wmask", {28'd0, bus.dmem_wmask}, 32'h1);
    chk("idle flush rmask", {28'd0, bus.dmem_rmask}, 32'h0);
    bus.dmem_resp = 1'b1;
    step();
    bus.dmem_resp = 1'b0;
    chk("idle flush st_done", {31'd0, bus.st_done}, 32'd1);
    step();

    // Reset mid-LD_WAIT, then a late resp
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h0000_0700; bus.ld_req_tag = 6'd3;
    step();
    bus.ld_req_valid = 1'b0;
    chk("rst pre busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    step();
    rst_n = 1'b1;
    step();
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h0000_0777;
    step();
    bus.dmem_resp = 1'b0;
    chk("late resp no valid", {31'd0, bus.ld_resp_valid}, 32'd0);
    chk("late resp idle", {31'd0, busy}, 32'd0);
    step();
    chk("late resp still none", {31'd0, bus.ld_resp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsq_dmem_arbiter.md
# lsq_dmem_arbiter

Sequences the single data-memory port between the load path (out-of-order load issue from the load queue) and the store path (in-order committed-store drain from the store queue). It grants one requester at a time and keeps exactly one transaction outstanding. It routes the response back to the requester, and drops in-flight load data on a branch flush. It sits between the LSQ and the data cache, and owns every `dmem_*` signal.

## Interface
- `TAG_WIDTH`, 6, width of the load tag (ROB index), returned with load data
- `STARVE_LIMIT`, 4, consecutive store grants with a load waiting before the load is forced through
- `clk` in 1: core clock
- `rst_n` in 1: asynchronous, active-low reset
- `br_flush` in 1: branch flush; kills the pending load and any unreturned load data
- `ld_req_valid` in 1, `ld_req_ready` out 1: load request handshake
- `ld_req_addr` in 32, `ld_req_rmask` in 4, `ld_req_tag` in TAG_WIDTH: load request payload
- `st_req_valid` in 1, `st_req_ready` out 1: committed-store request handshake
- `st_req_addr` in 32, `st_req_wmask` in 4, `st_req_wdata` in 32: store request payload (data already lane-aligned)
- `ld_resp_valid` out 1, `ld_resp_rdata` out 32, `ld_resp_tag` out TAG_WIDTH: load completion
- `st_done` out 1: store written; one-cycle pulse
- `dmem_addr` out 32, `dmem_rmask` out 4, `dmem_wmask` out 4, `dmem_wdata` out 32: cache request
- `dmem_rdata` in 32, `dmem_resp` in 1: cache response
- `busy` out 1: high when a transaction is outstanding

## Operation
- **FSM states:** IDLE, LD_WAIT, ST_WAIT, LD_DROP.
- **Ready signals:**
  - Both readys are combinational.
  - Both are zero outside IDLE.
  - At most one ready is high per cycle.
  - `ld_req_ready` is forced low while `br_flush` is high.
- **Grant rule in IDLE:**
  - Only one valid: grant it.
  - Both valid: grant the store, unless `starve_cnt == STARVE_LIMIT`, then grant the load.
- **`starve_cnt` (width `$clog2(STARVE_LIMIT+1)`):**
  - Increments, saturating, on each store grant while `ld_req_valid` is high.
  - Clears on any load grant, on `br_flush`, and in IDLE cycles when `ld_req_valid` is low.
- **On grant (valid && ready in cycle N):**
  - Latch the payload.
  - `dmem_addr = {addr[31:2],2'b00}`, held stable until `dmem_resp`.
  - `dmem_rmask` or `dmem_wmask` carries the mask for exactly cycle N+1, zero otherwise.
  - `dmem_wdata` is held with the address.
  - State moves to LD_WAIT or ST_WAIT.
- **LD_WAIT:**
  - `dmem_resp` without `br_flush`: register `dmem_rdata` and the tag; `ld_resp_valid` pulses the next cycle; go to IDLE.
  - `br_flush` without `dmem_resp`: go to LD_DROP.
  - `br_flush` together with `dmem_resp`: drop the data, no pulse, go to IDLE.
- **LD_DROP:** wait for `dmem_resp`, discard the data, go to IDLE. No `ld_resp_valid` is produced.
- **ST_WAIT:** ignores `br_flush` (the store is committed). On `dmem_resp`, `st_done` pulses the next cycle; go to IDLE.
- **Stray inputs:** `dmem_resp` in IDLE is ignored.
- **Status and defaults:**
  - `busy = (state != IDLE)`.
  - `ld_resp_rdata`/`ld_resp_tag` hold their last value when `ld_resp_valid` is low.

## Timing
- **Reset:** asserting `rst_n` low sets asynchronously:
  - state to IDLE and `starve_cnt` to 0;
  - all outputs to 0: `ld_resp_*`, `st_done`, `dmem_*` masks/addr/wdata, `busy`.
  - Reset mid-transaction abandons it; a late `dmem_resp` after reset is ignored in IDLE.
- **Load latency:** grant at N, mask at N+1, `dmem_resp` at R ≥ N+1, `ld_resp_valid` at R+1.
- **Back-to-back:** the next grant is possible at R+1, giving a minimum period of 2 cycles per transaction when the cache responds in the same cycle as the mask.
- **`st_done`:** asserted at R+1, same cadence as loads.
- **Response pulses:** `ld_resp_valid` and `st_done` are single-cycle and never high together.
- **No combinational paths** from `dmem_resp`/`dmem_rdata` to any output.

## Test plan
- **Reset:** assert `rst_n` low mid-LD_WAIT → all outputs 0 and `busy`=0. Release, then a `dmem_resp` pulse → no `ld_resp_valid`.
- **Single load:** `ld_req` addr 0x1000_0006, rmask 4'b1100, tag 5. Cache responds 3 cycles after the mask with 0xDEADBEEF. Expect `dmem_addr`=0x1000_0004, `dmem_rmask`=4'b1100 for one cycle, then `ld_resp_valid` with 0xDEADBEEF and tag 5 the cycle after resp.
- **Single store:** addr 0x2000_0008, wmask 4'b1111, wdata 0x12345678. Expect `dmem_wmask` pulse, stable addr/wdata, then `st_done` pulse.
- **Both valid continuously, STARVE_LIMIT=4, single-cycle cache:** grant order S,S,S,S,L,S,S,S,S,L. Check that no load waits more than 4 store transactions.
- **Flush while a load is outstanding:**
  - `br_flush` in LD_WAIT → LD_DROP, `busy` stays 1, resp dropped, no `ld_resp_valid`, next grant available after resp.
  - Repeat with flush coincident with resp → IDLE, no pulse.
- **Flush in ST_WAIT and in IDLE:**
  - `br_flush` in ST_WAIT → `st_done` still pulses.
  - `br_flush` in IDLE with both valid → store granted, `ld_req_ready`=0.
